// File: rtl/dsr_pkg.sv
// ----------------------------------------------------------------------------
// dsr_pkg : shared constants and helpers for the dynamic shift register family
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dsr_pkg;

  // Defaults shared with the single-bit variant.
  localparam int c_def_width    = 8;
  localparam int c_def_selwidth = 5;
  localparam int c_def_oreg     = 1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int fill_width(input int selwidth);
    return selwidth + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dynamic_shift_register_ext_if.sv
// ----------------------------------------------------------------------------
// dynamic_shift_register_ext_if : shift/tap bus of the dynamic shift register
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dynamic_shift_register_ext_if #(
  parameter int WIDTH    = 8,
  parameter int SELWIDTH = 5
);
  logic                CE;
  logic                CLR;
  logic [SELWIDTH-1:0] SEL;
  logic [WIDTH-1:0]    SI;
  logic [WIDTH-1:0]    DO;
  logic                DV;
  logic [SELWIDTH:0]   FILL;

  modport master (output CE, CLR, SEL, SI, input  DO, DV, FILL);
  modport slave  (input  CE, CLR, SEL, SI, output DO, DV, FILL);
endinterface

`default_nettype wire

// File: rtl/dsr_fill_counter.sv
// ----------------------------------------------------------------------------
// dsr_fill_counter : saturating count of valid taps, flushed by CLR
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dsr_fill_counter
  import dsr_pkg::*;
#(
  parameter  int DEPTH   = 32,
  localparam int c_cnt_w = clog2(DEPTH) + 1
) (
  input  wire logic               CLK,
  input  wire logic               RST,
  input  wire logic               CE,
  input  wire logic               CLR,
  output      logic [c_cnt_w-1:0] FILL
);

  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [c_cnt_w-1:0] fill_d;
  logic [c_cnt_w-1:0] fill_q;

  // A word shifted in during a flush is already valid, hence CE as the LSB.
  always_comb begin
    fill_d = fill_q;
    if (CLR) begin
      fill_d = {{(c_cnt_w-1){1'b0}}, CE};
    end else if (CE && (fill_q != c_full)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign FILL = fill_q;

endmodule

`default_nettype wire

// File: rtl/dynamic_shift_register_ext.sv
// ----------------------------------------------------------------------------
// dynamic_shift_register_ext : WIDTH-bit tapped delay line with valid tracking
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dynamic_shift_register_ext
  import dsr_pkg::*;
#(
  parameter int WIDTH    = c_def_width,
  parameter int SELWIDTH = c_def_selwidth,
  parameter int OREG     = c_def_oreg
) (
  input wire logic                     CLK,
  input wire logic                     RST,
  dynamic_shift_register_ext_if.slave  bus
);

  localparam int c_depth  = 2 ** SELWIDTH;
  localparam int c_fill_w = fill_width(SELWIDTH);

  logic [WIDTH-1:0]    taps_q [c_depth];
  logic [WIDTH-1:0]    taps_d [c_depth];
  logic [c_fill_w-1:0] fill;
  logic [WIDTH-1:0]    tap_sel;
  logic                sel_valid;

  always_comb begin
    taps_d = taps_q;
    if (bus.CE) begin
      taps_d[0] = bus.SI;
      for (int k = 1; k < c_depth; k++) begin
        taps_d[k] = taps_q[k-1];
      end
    end
  end

  // No reset on storage so the array maps onto shift-register primitives.
  always_ff @(posedge CLK) begin
    taps_q <= taps_d;
  end

  dsr_fill_counter #(
    .DEPTH (c_depth)
  ) u_fill (
    .CLK  (CLK),
    .RST  (RST),
    .CE   (bus.CE),
    .CLR  (bus.CLR),
    .FILL (fill)
  );

  assign tap_sel   = taps_q[bus.SEL];
  assign sel_valid = ({1'b0, bus.SEL} < fill);
  assign bus.FILL  = fill;

  if (OREG != 0) begin : g_oreg
    logic [WIDTH-1:0] do_d;
    logic [WIDTH-1:0] do_q;
    logic             dv_d;
    logic             dv_q;

    always_comb begin
      do_d = tap_sel;
      dv_d = sel_valid && !bus.CLR;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        do_q <= '0;
        dv_q <= 1'b0;
      end else begin
        do_q <= do_d;
        dv_q <= dv_d;
      end
    end

    assign bus.DO = do_q;
    assign bus.DV = dv_q;
  end else begin : g_comb
    assign bus.DO = tap_sel;
    assign bus.DV = sel_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_dynamic_shift_register_ext.sv
// ----------------------------------------------------------------------------
// tb_dynamic_shift_register_ext : directed checks on DEPTH=4 with OREG=1 and 0
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dynamic_shift_register_ext;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  dynamic_shift_register_ext_if #(.WIDTH(8), .SELWIDTH(2)) bus_r ();
  dynamic_shift_register_ext_if #(.WIDTH(8), .SELWIDTH(2)) bus_c ();

  dynamic_shift_register_ext #(.WIDTH(8), .SELWIDTH(2), .OREG(1)) u_dut_r (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_r)
  );

  dynamic_shift_register_ext #(.WIDTH(8), .SELWIDTH(2), .OREG(0)) u_dut_c (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic ce, input logic clr, input logic [1:0] sel, input logic [7:0] si);
    bus_r.CE = ce;  bus_r.CLR = clr;  bus_r.SEL = sel;  bus_r.SI = si;
    bus_c.CE = ce;  bus_c.CLR = clr;  bus_c.SEL = sel;  bus_c.SI = si;
    #2;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
    step();
    n_checks++; if (bus_r.FILL !== 3'd0) begin n_fail++; $display("FAIL reset_fill_r: got %0d want 0", bus_r.FILL); end
    n_checks++; if (bus_c.FILL !== 3'd0) begin n_fail++; $display("FAIL reset_fill_c: got %0d want 0", bus_c.FILL); end
    n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv_r: got %b want 0", bus_r.DV); end
    n_checks++; if (bus_c.DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv_c: got %b want 0", bus_c.DV); end
    n_checks++; if (bus_r.DO !== 8'h00) begin n_fail++; $display("FAIL reset_do_r: got %h want 00", bus_r.DO); end
    RST = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] si_tab [3];
    logic [2:0] fill_tab [3];
    si_tab   = '{8'h11, 8'h22, 8'h33};
    fill_tab = '{3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'd2, si_tab[i]);
      step();
      n_checks++; if (bus_r.FILL !== fill_tab[i]) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus_r.FILL, fill_tab[i]); end
      n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL fill_dv_r[%0d]: got %b want 0", i, bus_r.DV); end
    end
    drive(1'b0, 1'b0, 2'd2, 8'h00);
    n_checks++; if (bus_c.DO !== 8'h11) begin n_fail++; $display("FAIL fill_do_c: got %h want 11", bus_c.DO); end
    n_checks++; if (bus_c.DV !== 1'b1) begin n_fail++; $display("FAIL fill_dv_c: got %b want 1", bus_c.DV); end
    step();
    n_checks++; if (bus_r.DO !== 8'h11) begin n_fail++; $display("FAIL fill_do_r: got %h want 11", bus_r.DO); end
    n_checks++; if (bus_r.DV !== 1'b1) begin n_fail++; $display("FAIL fill_dv_r_late: got %b want 1", bus_r.DV); end
    n_checks++; if (bus_r.FILL !== 3'd3) begin n_fail++; $display("FAIL fill_hold: got %0d want 3", bus_r.FILL); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 2'd0, 8'hA0 + 8'(i));
      step();
      n_checks++; if (bus_r.FILL !== 3'd4) begin n_fail++; $display("FAIL sat_fill[%0d]: got %0d want 4", i, bus_r.FILL); end
    end
    drive(1'b0, 1'b0, 2'd3, 8'h00);
    n_checks++; if (bus_c.DO !== 8'hA2) begin n_fail++; $display("FAIL sat_sel3_do_c: got %h want a2", bus_c.DO); end
    n_checks++; if (bus_c.DV !== 1'b1) begin n_fail++; $display("FAIL sat_sel3_dv_c: got %b want 1", bus_c.DV); end
    step();
    n_checks++; if (bus_r.DO !== 8'hA2) begin n_fail++; $display("FAIL sat_sel3_do_r: got %h want a2", bus_r.DO); end
    n_checks++; if (bus_r.DV !== 1'b1) begin n_fail++; $display("FAIL sat_sel3_dv_r: got %b want 1", bus_r.DV); end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    n_checks++; if (bus_c.DO !== 8'hA5) begin n_fail++; $display("FAIL sat_sel0_do_c: got %h want a5", bus_c.DO); end
    step();
    n_checks++; if (bus_r.DO !== 8'hA5) begin n_fail++; $display("FAIL sat_sel0_do_r: got %h want a5", bus_r.DO); end
    n_checks++; if (bus_r.DV !== 1'b1) begin n_fail++; $display("FAIL sat_sel0_dv_r: got %b want 1", bus_r.DV); end
    n_checks++; if (bus_r.FILL !== 3'd4) begin n_fail++; $display("FAIL sat_fill_frozen: got %0d want 4", bus_r.FILL); end
  endtask

  task automatic test_clr_only();
    logic [7:0] old_tab [4];
    old_tab = '{8'hA5, 8'hA4, 8'hA3, 8'hA2};
    drive(1'b0, 1'b1, 2'd0, 8'h00);
    step();
    n_checks++; if (bus_r.FILL !== 3'd0) begin n_fail++; $display("FAIL clr_fill: got %0d want 0", bus_r.FILL); end
    n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL clr_dv_r: got %b want 0", bus_r.DV); end
    n_checks++; if (bus_r.DO !== 8'hA5) begin n_fail++; $display("FAIL clr_do_r: got %h want a5", bus_r.DO); end
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 1'b0, 2'(s), 8'h00);
      n_checks++; if (bus_c.DO !== old_tab[s]) begin n_fail++; $display("FAIL clr_do_c[%0d]: got %h want %h", s, bus_c.DO, old_tab[s]); end
      n_checks++; if (bus_c.DV !== 1'b0) begin n_fail++; $display("FAIL clr_dv_c[%0d]: got %b want 0", s, bus_c.DV); end
      step();
      n_checks++; if (bus_r.DO !== old_tab[s]) begin n_fail++; $display("FAIL clr_do_r[%0d]: got %h want %h", s, bus_r.DO, old_tab[s]); end
      n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL clr_dv_r[%0d]: got %b want 0", s, bus_r.DV); end
    end
  endtask

  task automatic test_clr_ce();
    drive(1'b1, 1'b1, 2'd0, 8'h5A);
    step();
    n_checks++; if (bus_r.FILL !== 3'd1) begin n_fail++; $display("FAIL clrce_fill: got %0d want 1", bus_r.FILL); end
    n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL clrce_dv_forced: got %b want 0", bus_r.DV); end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    n_checks++; if (bus_c.DO !== 8'h5A) begin n_fail++; $display("FAIL clrce_do_c: got %h want 5a", bus_c.DO); end
    n_checks++; if (bus_c.DV !== 1'b1) begin n_fail++; $display("FAIL clrce_dv_c: got %b want 1", bus_c.DV); end
    step();
    n_checks++; if (bus_r.DO !== 8'h5A) begin n_fail++; $display("FAIL clrce_do_r: got %h want 5a", bus_r.DO); end
    n_checks++; if (bus_r.DV !== 1'b1) begin n_fail++; $display("FAIL clrce_dv_r: got %b want 1", bus_r.DV); end
    drive(1'b0, 1'b0, 2'd1, 8'h00);
    n_checks++; if (bus_c.DV !== 1'b0) begin n_fail++; $display("FAIL clrce_sel1_dv_c: got %b want 0", bus_c.DV); end
    step();
    n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL clrce_sel1_dv_r: got %b want 0", bus_r.DV); end
    n_checks++; if (bus_r.DO !== 8'hA5) begin n_fail++; $display("FAIL clrce_sel1_do_r: got %h want a5", bus_r.DO); end
  endtask

  task automatic test_alternate();
    logic [7:0] do_c_tab [8];
    logic       dv_c_tab [8];
    logic [7:0] do_r_tab [8];
    logic       dv_r_tab [8];
    logic [2:0] fill_tab [8];
    do_c_tab = '{8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'hC2, 8'hC2, 8'hC0, 8'hC0};
    dv_c_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_r_tab = '{8'hA5, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'hC2, 8'hC2, 8'hC0};
    dv_r_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    fill_tab = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
    for (int i = 0; i < 8; i++) begin
      drive((i % 2) == 0, 1'b0, 2'(i % 4), 8'hC0 + 8'(i));
      n_checks++; if (bus_c.DO !== do_c_tab[i]) begin n_fail++; $display("FAIL alt_do_c[%0d]: got %h want %h", i, bus_c.DO, do_c_tab[i]); end
      n_checks++; if (bus_c.DV !== dv_c_tab[i]) begin n_fail++; $display("FAIL alt_dv_c[%0d]: got %b want %b", i, bus_c.DV, dv_c_tab[i]); end
      n_checks++; if (bus_r.DO !== do_r_tab[i]) begin n_fail++; $display("FAIL alt_do_r[%0d]: got %h want %h", i, bus_r.DO, do_r_tab[i]); end
      n_checks++; if (bus_r.DV !== dv_r_tab[i]) begin n_fail++; $display("FAIL alt_dv_r[%0d]: got %b want %b", i, bus_r.DV, dv_r_tab[i]); end
      n_checks++; if (bus_c.FILL !== fill_tab[i]) begin n_fail++; $display("FAIL alt_fill[%0d]: got %0d want %0d", i, bus_c.FILL, fill_tab[i]); end
      step();
    end
    n_checks++; if (bus_r.DO !== 8'hC0) begin n_fail++; $display("FAIL alt_do_r_last: got %h want c0", bus_r.DO); end
    n_checks++; if (bus_r.DV !== 1'b1) begin n_fail++; $display("FAIL alt_dv_r_last: got %b want 1", bus_r.DV); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    step();
    n_checks++; if (bus_r.DO !== 8'hC6) begin n_fail++; $display("FAIL arst_pre_do_r: got %h want c6", bus_r.DO); end
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if (bus_r.FILL !== 3'd0) begin n_fail++; $display("FAIL arst_fill_r: got %0d want 0", bus_r.FILL); end
    n_checks++; if (bus_c.FILL !== 3'd0) begin n_fail++; $display("FAIL arst_fill_c: got %0d want 0", bus_c.FILL); end
    n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL arst_dv_r: got %b want 0", bus_r.DV); end
    n_checks++; if (bus_c.DV !== 1'b0) begin n_fail++; $display("FAIL arst_dv_c: got %b want 0", bus_c.DV); end
    n_checks++; if (bus_r.DO !== 8'h00) begin n_fail++; $display("FAIL arst_do_r: got %h want 00", bus_r.DO); end
    #1;
    RST = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 8'h77);
    step();
    n_checks++; if (bus_r.FILL !== 3'd1) begin n_fail++; $display("FAIL arst_first_fill: got %0d want 1", bus_r.FILL); end
    n_checks++; if (bus_r.DV !== 1'b0) begin n_fail++; $display("FAIL arst_first_dv_r: got %b want 0", bus_r.DV); end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    n_checks++; if (bus_c.DO !== 8'h77) begin n_fail++; $display("FAIL arst_first_do_c: got %h want 77", bus_c.DO); end
    n_checks++; if (bus_c.DV !== 1'b1) begin n_fail++; $display("FAIL arst_first_dv_c: got %b want 1", bus_c.DV); end
    step();
    n_checks++; if (bus_r.DO !== 8'h77) begin n_fail++; $display("FAIL arst_next_do_r: got %h want 77", bus_r.DO); end
    n_checks++; if (bus_r.DV !== 1'b1) begin n_fail++; $display("FAIL arst_next_dv_r: got %b want 1", bus_r.DV); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill();
    test_saturate();
    test_clr_only();
    test_clr_ce();
    test_alternate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
